// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter and its round-robin picker.
// Holds the FSM state encoding, default sizing constants and a constant clog2.
package uart_arb_pkg;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_WAIT_DONE = 1'b1
  } arb_state_e;

  localparam int DEFAULT_NUM_REQ = 4;
  localparam int DEFAULT_DATA_W  = 8;

  // Ceiling log2 usable in parameter expressions; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or above the
// pointer, searching upward with an explicit wrap so any NUM_REQ works.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int IW      = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  output logic               o_valid,
  output logic [IW-1:0]      o_winner
);

  int w_idx;

  always_comb begin
    o_valid  = 1'b0;
    o_winner = '0;
    w_idx    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = int'(i_ptr) + i;
      if (w_idx >= NUM_REQ) begin
        w_idx = w_idx - NUM_REQ;
      end
      if (!o_valid && i_req[IW'(w_idx)]) begin
        o_valid  = 1'b1;
        o_winner = IW'(w_idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources.
// Optional watchdog on a stalled frame is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ     = DEFAULT_NUM_REQ,
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int TIMEOUT_CYC = 1048576
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_done,
  output logic                      busy,
  output logic [clog2(NUM_REQ)-1:0] grant_id,
  output logic                      timeout_err,
  output logic                      dbg_state
);

  localparam int IW = clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || DATA_W < 1 || TIMEOUT_CYC < 2) begin : g_param_check
    $error("uart_tx_arbiter: parameter out of range");
  end

  // Handshake: a requester holds req high with stable data until its one-cycle
  // ack; the transmitter gets a one-cycle tx_start with tx_data held until the
  // tx_done pulse, which is only honoured from the cycle after tx_start.

  arb_state_e              r_state;
  logic [IW-1:0]           r_ptr;
  logic [IW-1:0]           r_grant_id;
  logic [NUM_REQ-1:0]      r_ack;
  logic                    r_tx_start;
  logic [DATA_W-1:0]       r_tx_data;
  logic                    r_busy;

  logic                    w_valid;
  logic [IW-1:0]           w_winner;
  logic [IW-1:0]           w_next_ptr;
  logic [DATA_W-1:0]       w_bytes [NUM_REQ];

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0]           r_to_cnt;
  logic                    r_timeout_err;
`endif

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_bytes[g] = req_data[g*DATA_W +: DATA_W];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr_pick (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_valid  (w_valid),
    .o_winner (w_winner)
  );

  assign w_next_ptr = (w_winner == IW'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_ptr         <= '0;
      r_grant_id    <= '0;
      r_ack         <= '0;
      r_tx_start    <= 1'b0;
      r_tx_data     <= '0;
      r_busy        <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
`endif
    end else begin
      r_ack      <= '0;
      r_tx_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_state    <= ST_WAIT_DONE;
            r_tx_data  <= w_bytes[w_winner];
            r_tx_start <= 1'b1;
            r_ack      <= NUM_REQ'(1) << w_winner;
            r_grant_id <= w_winner;
            r_ptr      <= w_next_ptr;
            r_busy     <= 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
            r_to_cnt   <= '0;
`endif
          end
        end
        ST_WAIT_DONE: begin
          // r_tx_start still high means this is the start cycle itself.
          if (tx_done && !r_tx_start) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (r_to_cnt == TO_LAST) begin
            r_state       <= ST_IDLE;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
`endif
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ack       = r_ack;
  assign tx_start  = r_tx_start;
  assign tx_data   = r_tx_data;
  assign busy      = r_busy;
  assign grant_id  = r_grant_id;
  assign dbg_state = r_state;

`ifdef UART_ARB_TIMEOUT_EN
  assign timeout_err = r_timeout_err;
`else
  assign timeout_err = 1'b0;
`endif

endmodule
